// File: rtl/int_dispatch_queue_pkg.sv
// rtl/int_dispatch_queue_pkg.sv - core queue sizes and shared integer dispatch entry type
package int_dispatch_queue_pkg;

    localparam int INTDQ_SIZE     = 16;
    localparam int INTDQ_INPORTS  = 4;
    localparam int INTDQ_OUTPORTS = 4;

    localparam int ROB_IDX_W = 6;
    localparam int PREG_W    = 7;
    localparam int IMM_W     = 12;

    typedef enum logic [2:0] {
        INT_OP_ALU    = 3'd0,
        INT_OP_BRANCH = 3'd1,
        INT_OP_MUL    = 3'd2,
        INT_OP_DIV    = 3'd3,
        INT_OP_CSR    = 3'd4
    } int_op_e;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        int_op_e              op;
        logic [PREG_W-1:0]    prd;
        logic [PREG_W-1:0]    prs1;
        logic [PREG_W-1:0]    prs2;
        logic [IMM_W-1:0]     imm;
    } intDQEntry_t;

endpackage

// File: rtl/int_dispatch_queue_if.sv
// rtl/int_dispatch_queue_if.sv - rename/commit/exe-side bundle of the integer dispatch queue
interface int_dispatch_queue_if
    import int_dispatch_queue_pkg::*;
#(
    parameter int DEPTH    = INTDQ_SIZE,
    parameter int INPORTS  = INTDQ_INPORTS,
    parameter int OUTPORTS = INTDQ_OUTPORTS
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic                             i_squash_vld;
    logic                             o_can_enq;
    logic        [INPORTS-1:0]        i_enq_vld;
    intDQEntry_t [INPORTS-1:0]        i_enq_info;
    logic        [OUTPORTS-1:0]       o_deq_vld;
    intDQEntry_t [OUTPORTS-1:0]       o_deq_info;
    logic        [OUTPORTS-1:0]       i_deq_req;
    logic        [CW-1:0]             o_count;

    modport master (
        output i_squash_vld,
        output i_enq_vld,
        output i_enq_info,
        output i_deq_req,
        input  o_can_enq,
        input  o_deq_vld,
        input  o_deq_info,
        input  o_count
    );

    modport slave (
        input  i_squash_vld,
        input  i_enq_vld,
        input  i_enq_info,
        input  i_deq_req,
        output o_can_enq,
        output o_deq_vld,
        output o_deq_info,
        output o_count
    );

endinterface

// File: rtl/int_dispatch_queue.sv
// rtl/int_dispatch_queue.sv - circular integer dispatch queue, INPORTS in / OUTPORTS out
// Optional feature: define INTDQ_STALL_CNT_EN to add the o_stall_cycles counter.
module int_dispatch_queue
    import int_dispatch_queue_pkg::*;
#(
    parameter int DEPTH    = INTDQ_SIZE,
    parameter int INPORTS  = INTDQ_INPORTS,
    parameter int OUTPORTS = INTDQ_OUTPORTS
) (
    input  logic                 clk,
    input  logic                 rst,
    int_dispatch_queue_if.slave  dq
`ifdef INTDQ_STALL_CNT_EN
    ,
    output logic [31:0]          o_stall_cycles
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] count;
    logic [PW-1:0] enq_k;
    logic [PW-1:0] deq_m;
    logic          can_enq;
    logic          do_enq;

    intDQEntry_t   mem [DEPTH];

    // The extra wrap bit makes tail - head the exact occupancy, full included.
    assign count   = tail - head;
    assign can_enq = (count <= PW'(DEPTH - INPORTS));
    assign do_enq  = can_enq && !dq.i_squash_vld;

    always_comb begin
        enq_k = '0;
        for (int i = 0; i < INPORTS; i++) begin
            enq_k = enq_k + PW'(dq.i_enq_vld[i]);
        end
    end

    always_comb begin
        deq_m = '0;
        for (int i = 0; i < OUTPORTS; i++) begin
            deq_m = deq_m + PW'(dq.i_deq_req[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else if (dq.i_squash_vld) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head + deq_m;
            if (do_enq) begin
                tail <= tail + enq_k;
            end
        end
    end

    // Payload is never cleared; pointers alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (!rst && do_enq) begin
            for (int i = 0; i < INPORTS; i++) begin
                if (dq.i_enq_vld[i]) begin
                    mem[tail[IW-1:0] + IW'(i)] <= dq.i_enq_info[i];
                end
            end
        end
    end

    for (genvar g = 0; g < OUTPORTS; g++) begin : g_deq
        assign dq.o_deq_vld[g]  = (count > PW'(g));
        assign dq.o_deq_info[g] = mem[head[IW-1:0] + IW'(g)];
    end

    assign dq.o_can_enq = can_enq;
    assign dq.o_count   = count;

`ifdef INTDQ_STALL_CNT_EN
    // Blocked rename cycles; survives squash so it measures the whole run.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_stall_cycles <= '0;
        end else if ((|dq.i_enq_vld) && !can_enq && (o_stall_cycles != '1)) begin
            o_stall_cycles <= o_stall_cycles + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_enq_prefix: assert property (@(posedge clk) disable iff (rst)
        (dq.i_enq_vld & (dq.i_enq_vld + INPORTS'(1))) == '0);

    a_deq_prefix: assert property (@(posedge clk) disable iff (rst)
        (dq.i_deq_req & (dq.i_deq_req + OUTPORTS'(1))) == '0);

    a_deq_subset: assert property (@(posedge clk) disable iff (rst)
        (dq.i_deq_req & ~dq.o_deq_vld) == '0);
`endif

endmodule

// File: tb/tb_int_dispatch_queue.sv
// tb/tb_int_dispatch_queue.sv - randomized self-checking bench for int_dispatch_queue
module tb_int_dispatch_queue;
    import int_dispatch_queue_pkg::*;

    localparam int DEPTH    = 16;
    localparam int INPORTS  = 4;
    localparam int OUTPORTS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int_dispatch_queue_if #(.DEPTH(DEPTH), .INPORTS(INPORTS), .OUTPORTS(OUTPORTS)) dq ();

`ifdef INTDQ_STALL_CNT_EN
    logic [31:0] stall_cycles;
    longint      stall_exp;
`endif

    int_dispatch_queue #(.DEPTH(DEPTH), .INPORTS(INPORTS), .OUTPORTS(OUTPORTS)) dut (
        .clk            (clk),
        .rst            (rst),
        .dq             (dq)
`ifdef INTDQ_STALL_CNT_EN
        ,
        .o_stall_cycles (stall_cycles)
`endif
    );

    intDQEntry_t mq[$];
    int checks = 0;
    int errors = 0;

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic intDQEntry_t rand_entry(int rob);
        intDQEntry_t e;
        e.rob_idx = ROB_IDX_W'(rob);
        e.op      = int_op_e'($urandom_range(0, 4));
        e.prd     = PREG_W'($urandom);
        e.prs1    = PREG_W'($urandom);
        e.prs2    = PREG_W'($urandom);
        e.imm     = IMM_W'($urandom);
        return e;
    endfunction

    task automatic set_in(int en, int rob_base, int dn, bit sq);
        dq.i_enq_vld = '0;
        for (int i = 0; i < INPORTS; i++) begin
            dq.i_enq_info[i] = rand_entry(rob_base + i);
            if (i < en) dq.i_enq_vld[i] = 1'b1;
        end
        dq.i_deq_req = '0;
        for (int i = 0; i < dn; i++) dq.i_deq_req[i] = 1'b1;
        dq.i_squash_vld = sq;
    endtask

    // Reference: a FIFO of entries; capacity check uses occupancy before the edge.
    task automatic tick();
        int  k;
        int  m;
        bit  can;
        intDQEntry_t ins[$];
        can = (DEPTH - mq.size()) >= INPORTS;
        k   = $countones(dq.i_enq_vld);
        m   = $countones(dq.i_deq_req);
        for (int j = 0; j < k; j++) ins.push_back(dq.i_enq_info[j]);
`ifdef INTDQ_STALL_CNT_EN
        if (rst) stall_exp = 0;
        else if (k > 0 && !can && stall_exp < 64'hFFFF_FFFF) stall_exp++;
`endif
        @(posedge clk);
        if (rst || dq.i_squash_vld) begin
            mq.delete();
        end else begin
            for (int j = 0; j < m; j++) void'(mq.pop_front());
            if (can) foreach (ins[j]) mq.push_back(ins[j]);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(4, 0, 0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        set_in(0, 0, 0, 1'b0);
        tick();
        #1;
        checks++; if (dq.o_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", dq.o_count); end
        checks++; if (dq.o_deq_vld !== 4'b0000) begin errors++; $display("FAIL reset_deq_vld got %b exp 0000", dq.o_deq_vld); end
        checks++; if (dq.o_can_enq !== 1'b1) begin errors++; $display("FAIL reset_can_enq got %b exp 1", dq.o_can_enq); end
`ifdef INTDQ_STALL_CNT_EN
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
`endif
    endtask

    task automatic test_enq4();
        set_in(4, 0, 0, 1'b0);
        #1;
        checks++; if (dq.o_count !== 5'd0) begin errors++; $display("FAIL enq4_no_bypass got %0d exp 0", dq.o_count); end
        tick();
        set_in(0, 0, 0, 1'b0);
        #1;
        checks++; if (dq.o_count !== 5'd4) begin errors++; $display("FAIL enq4_count got %0d exp 4", dq.o_count); end
        checks++; if (dq.o_deq_vld !== 4'b1111) begin errors++; $display("FAIL enq4_deq_vld got %b exp 1111", dq.o_deq_vld); end
        checks++; if (dq.o_deq_info[0].rob_idx !== 6'd0) begin errors++; $display("FAIL enq4_rob0 got %0d exp 0", dq.o_deq_info[0].rob_idx); end
        checks++; if (dq.o_deq_info[3].rob_idx !== 6'd3) begin errors++; $display("FAIL enq4_rob3 got %0d exp 3", dq.o_deq_info[3].rob_idx); end
    endtask

    task automatic test_full();
`ifdef INTDQ_STALL_CNT_EN
        logic [31:0] s0;
`endif
        set_in(4, 4, 0, 1'b0);  tick();
        set_in(4, 8, 0, 1'b0);  tick();
        set_in(1, 12, 0, 1'b0); tick();
        set_in(0, 0, 0, 1'b0);
        #1;
        checks++; if (dq.o_count !== 5'd13) begin errors++; $display("FAIL full_count got %0d exp 13", dq.o_count); end
        checks++; if (dq.o_can_enq !== 1'b0) begin errors++; $display("FAIL full_can_enq got %b exp 0", dq.o_can_enq); end
`ifdef INTDQ_STALL_CNT_EN
        s0 = stall_cycles;
`endif
        for (int c = 0; c < 3; c++) begin
            set_in(4, 20, 0, 1'b0);
            tick();
        end
        set_in(0, 0, 0, 1'b0);
        #1;
        checks++; if (dq.o_count !== 5'd13) begin errors++; $display("FAIL full_blocked_count got %0d exp 13", dq.o_count); end
        checks++; if (dq.o_deq_info[0].rob_idx !== 6'd0) begin errors++; $display("FAIL full_head got %0d exp 0", dq.o_deq_info[0].rob_idx); end
`ifdef INTDQ_STALL_CNT_EN
        checks++; if (stall_cycles !== s0 + 32'd3) begin errors++; $display("FAIL full_stall got %0d exp %0d", stall_cycles, s0 + 32'd3); end
        checks++; if (stall_cycles !== 32'(stall_exp)) begin errors++; $display("FAIL full_stall_model got %0d exp %0d", stall_cycles, stall_exp); end
`endif
    endtask

    task automatic test_simul();
        set_in(0, 0, 0, 1'b1); tick();
        set_in(4, 0, 0, 1'b0); tick();
        set_in(3, 4, 2, 1'b0); tick();
        set_in(0, 0, 0, 1'b0);
        #1;
        checks++; if (dq.o_count !== 5'd5) begin errors++; $display("FAIL simul_count got %0d exp 5", dq.o_count); end
        checks++; if (dq.o_deq_info[0].rob_idx !== 6'd2) begin errors++; $display("FAIL simul_head got %0d exp 2", dq.o_deq_info[0].rob_idx); end
        checks++; if (dq.o_deq_info[2].rob_idx !== 6'd4) begin errors++; $display("FAIL simul_third got %0d exp 4", dq.o_deq_info[2].rob_idx); end
    endtask

    task automatic test_squash();
        set_in(0, 0, 0, 1'b1); tick();
        set_in(4, 0, 0, 1'b0); tick();
        set_in(4, 4, 0, 1'b0); tick();
        set_in(2, 8, 0, 1'b0); tick();
        set_in(4, 10, 2, 1'b1);
        #1;
        checks++; if (dq.o_deq_info[1].rob_idx !== 6'd1) begin errors++; $display("FAIL squash_pre_view got %0d exp 1", dq.o_deq_info[1].rob_idx); end
        tick();
        set_in(0, 0, 0, 1'b0);
        #1;
        checks++; if (dq.o_count !== 5'd0) begin errors++; $display("FAIL squash_count got %0d exp 0", dq.o_count); end
        checks++; if (dq.o_deq_vld !== 4'b0000) begin errors++; $display("FAIL squash_deq_vld got %b exp 0000", dq.o_deq_vld); end
        checks++; if (dq.o_can_enq !== 1'b1) begin errors++; $display("FAIL squash_can_enq got %b exp 1", dq.o_can_enq); end
        set_in(2, 50, 0, 1'b0); tick();
        set_in(0, 0, 0, 1'b0);
        #1;
        checks++; if (dq.o_deq_info[0].rob_idx !== 6'd50) begin errors++; $display("FAIL squash_reenq got %0d exp 50", dq.o_deq_info[0].rob_idx); end
    endtask

    task automatic test_wrap();
        int next_rob = 0;
        int expect_rob = 0;
        int cyc = 0;
        int en;
        int dn;
        set_in(0, 0, 0, 1'b1); tick();
        while (expect_rob < 40 && cyc < 1000) begin
            en = (next_rob < 40) ? $urandom_range(0, min2(INPORTS, 40 - next_rob)) : 0;
            dn = $urandom_range(0, min2(mq.size(), OUTPORTS));
            set_in(en, next_rob, dn, 1'b0);
            #1;
            for (int i = 0; i < dn; i++) begin
                checks++;
                if (dq.o_deq_info[i].rob_idx !== ROB_IDX_W'(expect_rob)) begin
                    errors++;
                    $display("FAIL wrap_order port %0d got %0d exp %0d", i, dq.o_deq_info[i].rob_idx, expect_rob);
                end
                expect_rob++;
            end
            if ((DEPTH - mq.size()) >= INPORTS) next_rob += en;
            tick();
            cyc++;
        end
        set_in(0, 0, 0, 1'b0);
        #1;
        checks++; if (expect_rob != 40) begin errors++; $display("FAIL wrap_timeout drained %0d exp 40", expect_rob); end
        checks++; if (dq.o_count !== 5'd0) begin errors++; $display("FAIL wrap_empty got %0d exp 0", dq.o_count); end
    endtask

    task automatic test_random();
        logic [OUTPORTS-1:0] ev;
        bit sq;
        for (int c = 0; c < 400; c++) begin
            sq  = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 63) == 0);
            set_in($urandom_range(0, INPORTS), $urandom_range(0, 63),
                   $urandom_range(0, min2(mq.size(), OUTPORTS)), sq);
            #1;
            for (int i = 0; i < OUTPORTS; i++) ev[i] = (mq.size() > i);
            checks++; if (dq.o_count !== 5'(mq.size())) begin errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", c, dq.o_count, mq.size()); end
            checks++; if (dq.o_can_enq !== ((DEPTH - mq.size()) >= INPORTS)) begin errors++; $display("FAIL rand_can_enq cyc %0d got %b", c, dq.o_can_enq); end
            checks++; if (dq.o_deq_vld !== ev) begin errors++; $display("FAIL rand_deq_vld cyc %0d got %b exp %b", c, dq.o_deq_vld, ev); end
            for (int i = 0; i < min2(mq.size(), OUTPORTS); i++) begin
                checks++;
                if (dq.o_deq_info[i] !== mq[i]) begin
                    errors++;
                    $display("FAIL rand_info cyc %0d port %0d got %h exp %h", c, i, dq.o_deq_info[i], mq[i]);
                end
            end
            tick();
        end
        rst = 1'b0;
        set_in(0, 0, 0, 1'b0);
        tick();
`ifdef INTDQ_STALL_CNT_EN
        checks++; if (stall_cycles !== 32'(stall_exp)) begin errors++; $display("FAIL rand_stall got %0d exp %0d", stall_cycles, stall_exp); end
`endif
    endtask

    initial begin
`ifdef INTDQ_STALL_CNT_EN
        stall_exp = 0;
`endif
        rst = 1'b1;
        set_in(0, 0, 0, 1'b0);
        #1;
        test_reset();
        test_enq4();
        test_full();
        test_simul();
        test_squash();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_dispatch_queue.md
INT_DISPATCH_QUEUE -- requirements
Module: int_dispatch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count (power of two, >= 2*INPORTS).
REQ-002 SHALL have parameter INPORTS, default 4, enqueue width from rename.
REQ-003 SHALL have parameter OUTPORTS, default 4, dequeue width to exeIntBlock.
REQ-004 SHALL have port clk  input  1  core clock; one clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_squash_vld  input  1  squash from commit; flushes queue.
REQ-007 SHALL have port o_can_enq  output  1  queue can take a full INPORTS group this cycle.
REQ-008 SHALL have port i_enq_vld  input  INPORTS  per-port enqueue valid; prefix from port 0.
REQ-009 SHALL have port i_enq_info  input  INPORTS x intDQEntry_t  enqueue payload.
REQ-010 SHALL have port o_deq_vld  output  OUTPORTS  per-port entry present; prefix from port 0.
REQ-011 SHALL have port o_deq_info  output  OUTPORTS x intDQEntry_t  oldest entries, port 0 oldest.
REQ-012 SHALL have port i_deq_req  input  OUTPORTS  per-port consumed; prefix, subset of o_deq_vld.
REQ-013 SHALL have port o_count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-014 Storage SHALL be circular: head (oldest) and tail pointers, each with one wrap bit beyond clog2(DEPTH).
REQ-015 o_can_enq SHALL be 1 iff free slots (DEPTH - count) >= INPORTS, computed from registered state only (no dependency on i_deq_req).
REQ-016 Enqueue SHALL occur iff o_can_enq && !i_squash_vld; k = popcount(i_enq_vld) entries written at tail..tail+k-1 in port order; tail += k.
REQ-017 i_enq_vld with o_can_enq=0 SHALL be ignored (no write, no pointer change); rename holds.
REQ-018 o_deq_vld[i] SHALL be 1 iff count > i; o_deq_info[i] = entry at head+i (mod DEPTH), combinational from registers.
REQ-019 Dequeue SHALL remove m = popcount(i_deq_req) entries; head += m; i_deq_req outside prefix or beyond o_deq_vld is illegal (assertion).
REQ-020 Simultaneous enqueue and dequeue SHALL both apply; count_next = count + k - m.
REQ-021 Entries enqueued in cycle N SHALL first appear on o_deq_* in cycle N+1 (no bypass).
REQ-022 Pointer wrap: index arithmetic mod DEPTH; full = (head idx == tail idx) && wrap bits differ; empty = pointers equal.
REQ-023 i_squash_vld SHALL in the next cycle set head = tail = 0, count = 0; overrides same-cycle enqueue and dequeue.
REQ-024 Dequeue in a squash cycle SHALL not affect state; o_deq_* still reflect pre-squash contents that cycle.
REQ-025 Payload RAM SHALL not need clearing; validity derives from pointers only.

Reset
REQ-026 rst SHALL set head = tail = 0, count = 0; hence o_deq_vld = 0, o_can_enq = 1, o_count = 0 next cycle.
REQ-027 rst SHALL take priority over squash, enqueue and dequeue; payload contents undefined after reset.

Configuration
REQ-028 Macro INTDQ_STALL_CNT_EN defined: SHALL add output o_stall_cycles (32-bit) counting cycles with |i_enq_vld && !o_can_enq; saturates at 2^32-1; cleared by rst only, not squash.
REQ-029 Macro INTDQ_STALL_CNT_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 intDQEntry_t SHALL stay in the shared core type header; default DEPTH constant INTDQ_SIZE SHALL live in core_define with other queue sizes.
REQ-031 No sub-module: storage, pointers and popcount logic inline; prefix-check assertions under simulation-only guard.

Verification
REQ-032 Reset, then idle -> o_count=0, o_deq_vld=4'b0000, o_can_enq=1.
REQ-033 Enq 4 (i_enq_vld=4'b1111, rob_idx 0..3), no deq -> next cycle o_count=4, o_deq_vld=4'b1111, o_deq_info[0].rob_idx=0.
REQ-034 Fill to 13 entries -> o_can_enq=0; enq attempt ignored, count stays 13; with INTDQ_STALL_CNT_EN o_stall_cycles increments by 1 per blocked cycle.
REQ-035 count=4, enq 3 and i_deq_req=4'b0011 same cycle -> count=5, o_deq_info[0] = old third entry.
REQ-036 Wrap: drive 40 enq/deq entries with rob_idx 0..39 through DEPTH=16 -> dequeue order exactly 0..39, no loss or duplication.
REQ-037 count=10, i_squash_vld with enq 4 and deq 2 same cycle -> next cycle count=0, o_deq_vld=0, o_can_enq=1.
